// File: rtl/bin2bcd_seg_pkg.sv
// Shared types and constants for the bin2bcd_seg binary-to-BCD converter.
// Optional raw-hex display path is enabled with BIN2BCD_HEX_BYPASS_EN.
package bin2bcd_seg_pkg;

    localparam int DEF_BIN_W  = 32;
    localparam int DEF_DIGITS = 8;

    // Largest value that fits in eight decimal digits, and its saturated display.
    localparam logic [31:0] BCD_MAX = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT = 32'h9999_9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bin2bcd_seg_bcd_digit_adj.sv
// One BCD digit correction stage: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin2bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = add3_if_ge5(digit);

endmodule

// File: rtl/bin2bcd_seg.sv
// Iterative shift-add-3 binary to packed BCD converter, one bit per clock.
// Define BIN2BCD_HEX_BYPASS_EN to add the i_hex raw-hex pass-through input.
module bin2bcd_seg
    import bin2bcd_seg_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      i_bin,
`ifdef BIN2BCD_HEX_BYPASS_EN
    input  logic                  i_hex,
`endif
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    state_t             state_reg;
    logic [BCD_W-1:0]   acc_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt_reg;
`ifdef BIN2BCD_HEX_BYPASS_EN
    logic               hex_reg;
`endif

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_next;
    logic [BIN_W-1:0]   bin_next;
    logic               over_range;
    logic               to_done;
    logic               unused_top;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (acc_reg[gi*4 +: 4]),
                .adjusted (acc_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // The top bit shifted out of the accumulator is always zero for in-range inputs.
    assign unused_top = acc_adj[BCD_W-1];
    assign acc_next   = {acc_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
    assign bin_next   = {bin_reg[BIN_W-2:0], 1'b0};
    assign over_range = 64'(i_bin) > 64'(BCD_MAX);

`ifdef BIN2BCD_HEX_BYPASS_EN
    assign to_done = over_range | i_hex;
`else
    assign to_done = over_range;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            bin_reg   <= '0;
            cnt_reg   <= '0;
            o_bcd     <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_ovf     <= 1'b0;
`ifdef BIN2BCD_HEX_BYPASS_EN
            hex_reg   <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg <= i_bin;
                        o_busy  <= 1'b1;
`ifdef BIN2BCD_HEX_BYPASS_EN
                        hex_reg <= i_hex;
`endif
                        if (to_done) begin
                            state_reg <= ST_DONE;
                        end else begin
                            acc_reg   <= '0;
                            cnt_reg   <= '0;
                            state_reg <= ST_CONV;
                        end
                    end
                end

                ST_CONV: begin
                    acc_reg <= acc_next;
                    bin_reg <= bin_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        o_bcd     <= acc_next;
                        o_ovf     <= 1'b0;
                        o_valid   <= 1'b1;
                        o_busy    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_DONE: begin
`ifdef BIN2BCD_HEX_BYPASS_EN
                    if (hex_reg) begin
                        o_bcd <= BCD_W'(bin_reg);
                        o_ovf <= 1'b0;
                    end else begin
                        o_bcd <= BCD_W'(BCD_SAT);
                        o_ovf <= 1'b1;
                    end
`else
                    o_bcd <= BCD_W'(BCD_SAT);
                    o_ovf <= 1'b1;
`endif
                    o_valid   <= 1'b1;
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
